roi_shift_harness: RTL

//  Parametrised serial-to-parallel / parallel-to-serial test harness that feeds a fuzzer ROI.

---
 rtl/roi_harness_pkg.sv | 28 ++
 rtl/roi_shift_chain.sv | 52 +++++
 rtl/roi_shift_harness.sv | 110 +++++++++++
 3 files changed

// File: rtl/roi_harness_pkg.sv
// Shared width derivations and defaults for the ROI shift harness.
// The beat counter is at least one bit wide so a single-beat word still has a legal port.
package roi_harness_pkg;

    localparam int DIN_N_DEF   = 256;
    localparam int DOUT_N_DEF  = 256;
    localparam int FRAME_W_DEF = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int beats(input int din_n, input int lanes);
        return din_n / lanes;
    endfunction

    function automatic int beat_w(input int din_n, input int lanes);
        int w;
        w = clog2(beats(din_n, lanes));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/roi_shift_chain.sv
// LANES-wide shift register with a priority parallel load and a top-LANES tap.
// o_q_nxt exposes the value the register takes at the next edge, so callers can capture it early.
module roi_shift_chain
    import roi_harness_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_shift_en,
    input  logic [LANES-1:0] i_di,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [LANES-1:0] o_tap,
    output logic [WIDTH-1:0] o_q_nxt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_q_nxt;

    generate
        if (WIDTH > LANES) begin : g_shift_wide
            assign w_shifted = {r_q[WIDTH-LANES-1:0], i_di};
        end else begin : g_shift_single
            assign w_shifted = i_di;
        end
    endgenerate

    // Parallel load wins over a shift in the same cycle.
    always_comb begin
        w_q_nxt = r_q;
        if (i_load) begin
            w_q_nxt = i_pdata;
        end else if (i_shift_en) begin
            w_q_nxt = w_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_q_nxt = w_q_nxt;
    assign o_tap   = r_q[WIDTH-1 -: LANES];

endmodule

// File: rtl/roi_shift_harness.sv
// Serial-to-parallel feeder and parallel-to-serial drain around a fuzzer ROI.
// Input protocol: i_shift_en moves both chains by one beat; a load (stb or auto) swaps din/dout words.
module roi_shift_harness
    import roi_harness_pkg::*;
#(
    parameter int DIN_N    = DIN_N_DEF,
    parameter int DOUT_N   = DOUT_N_DEF,
    parameter int LANES    = 1,
    parameter bit AUTO_STB = 1'b0,
    parameter int FRAME_W  = FRAME_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANES-1:0]                 i_di,
    input  logic                             i_shift_en,
    input  logic                             i_stb,
    output logic [LANES-1:0]                 o_do,
    output logic [DIN_N-1:0]                 o_din,
    input  logic [DOUT_N-1:0]                i_dout,
    output logic                             o_load_pulse,
    output logic [beat_w(DIN_N, LANES)-1:0]  o_beat_cnt,
    output logic [FRAME_W-1:0]               o_frame_cnt
);

    localparam int BEATS = beats(DIN_N, LANES);
    localparam int BW    = beat_w(DIN_N, LANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    generate
        if ((LANES < 1) || ((DIN_N % LANES) != 0) || ((DOUT_N % LANES) != 0)) begin : g_bad_params
            $fatal(1, "roi_shift_harness: LANES must be >= 1 and divide DIN_N and DOUT_N");
        end
    endgenerate

    logic [LANES-1:0]  w_din_tap;
    logic [DIN_N-1:0]  w_din_shr_nxt;
    logic [DOUT_N-1:0] w_dout_shr_nxt;
    logic              w_load;
    logic [BW-1:0]     w_beat_nxt;

    logic [DIN_N-1:0]   r_din;
    logic [BW-1:0]      r_beat_cnt;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_load_pulse;

    roi_shift_chain #(
        .WIDTH (DIN_N),
        .LANES (LANES)
    ) u_din_chain (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (i_shift_en),
        .i_di       (i_di),
        .i_load     (1'b0),
        .i_pdata    ({DIN_N{1'b0}}),
        .o_tap      (w_din_tap),
        .o_q_nxt    (w_din_shr_nxt)
    );

    // The oldest input bits loop back into the output chain between loads.
    roi_shift_chain #(
        .WIDTH (DOUT_N),
        .LANES (LANES)
    ) u_dout_chain (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (i_shift_en),
        .i_di       (w_din_tap),
        .i_load     (w_load),
        .i_pdata    (i_dout),
        .o_tap      (o_do),
        .o_q_nxt    (w_dout_shr_nxt)
    );

    assign w_load = AUTO_STB ? (i_shift_en && (r_beat_cnt == LAST_BEAT)) : i_stb;

    // A manual strobe restarts word framing even if a beat arrives with it.
    always_comb begin
        w_beat_nxt = r_beat_cnt;
        if (!AUTO_STB && i_stb) begin
            w_beat_nxt = '0;
        end else if (i_shift_en) begin
            w_beat_nxt = (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din        <= '0;
            r_beat_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_load_pulse <= 1'b0;
        end else begin
            r_beat_cnt   <= w_beat_nxt;
            r_load_pulse <= w_load;
            if (w_load) begin
                r_din <= w_din_shr_nxt;
                if (r_frame_cnt != {FRAME_W{1'b1}}) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign o_din        = r_din;
    assign o_beat_cnt   = r_beat_cnt;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_load_pulse = r_load_pulse;

endmodule
